// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3).
//
// A conversion is accepted from IDLE on start, takes exactly BIN_W clock
// edges, and ends with a one-cycle done pulse as the results are loaded.
// Values above 10^DIGITS-1 saturate to all nines and raise overflow.
//
// Parameters:
//   BIN_W    binary input width (4..20)
//   DIGITS   number of BCD output digits (1..6)
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   start    conversion request, sampled only while ready=1
//   bin      unsigned binary input, captured on the accepting edge
//   ready    high while idle
//   done     one-cycle pulse: bcd/blank/overflow just loaded
//   bcd      packed BCD result, digit 0 (units) in bits [3:0]
//   overflow last captured bin exceeded 10^DIGITS-1
//   blank    bit k set: digit k is a suppressible leading zero
module bin2bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin,
    output logic                ready,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                overflow,
    output logic [DIGITS-1:0]   blank
);

    // Digits needed to hold 2^w-1 without losing a carry.
    function automatic int work_digits(input int w);
        longint maxv;
        longint p;
        int     n;
        maxv = (longint'(1) << w) - 1;
        p    = 10;
        n    = 1;
        while (p <= maxv) begin
            p = p * 10;
            n = n + 1;
        end
        return n;
    endfunction

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam int     WD    = work_digits(BIN_W);
    localparam int     OW    = (WD > DIGITS) ? WD : DIGITS;
    // One spare zero digit keeps the "above DIGITS" slice non-empty.
    localparam int     EW    = 4 * (OW + 1);
    localparam int     CW    = $clog2(BIN_W + 1);
    localparam longint LIMIT = pow10(DIGITS) - 1;
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [4*WD-1:0]     work_bcd;
    logic [BIN_W-1:0]    sh;
    logic                ovf_pend;

    logic [4*WD-1:0]          adj;
    logic [4*WD+BIN_W-1:0]    shifted;
    logic [4*WD-1:0]          next_bcd;
    logic [BIN_W-1:0]         next_sh;
    logic [EW-1:0]            ext;
    logic                     sat;
    logic [4*DIGITS-1:0]      out_bcd;
    logic [DIGITS-1:0]        blank_n;
    logic                     all_zero;
    logic                     over_limit;

    assign ready      = (state == IDLE);
    assign over_limit = (longint'(bin) > LIMIT);

    always_comb begin
        adj = work_bcd;
        for (int unsigned i = 0; i < WD; i++) begin
            if (work_bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = work_bcd[4*i +: 4] + 4'd3;
        end
        shifted  = {adj, sh} << 1;
        next_bcd = shifted[4*WD+BIN_W-1:BIN_W];
        next_sh  = shifted[BIN_W-1:0];

        // Any nonzero digit above DIGITS means the value exceeds the limit,
        // which matches the compare registered at start.
        ext     = EW'(next_bcd);
        sat     = ovf_pend | (|ext[EW-1:4*DIGITS]);
        out_bcd = sat ? {DIGITS{4'h9}} : ext[4*DIGITS-1:0];

        // Scan from the most significant digit down; a digit is blank while
        // every digit at or above it is zero. Units are never blanked.
        all_zero = 1'b1;
        blank_n  = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            all_zero = all_zero & (out_bcd[4*(DIGITS-1-i) +: 4] == 4'd0);
            if ((DIGITS - 1 - i) != 0)
                blank_n[DIGITS-1-i] = all_zero & ~sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            work_bcd <= '0;
            sh       <= '0;
            ovf_pend <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
            blank    <= BLANK_RST;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sh       <= bin;
                        work_bcd <= '0;
                        cnt      <= CW'(BIN_W);
                        ovf_pend <= over_limit;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_bcd <= next_bcd;
                    sh       <= next_sh;
                    cnt      <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state    <= IDLE;
                        done     <= 1'b1;
                        bcd      <= out_bcd;
                        blank    <= blank_n;
                        overflow <= sat;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
